nl2_dbank_cmd_sched: RTL and testbench

- Per-bank command scheduler in front of the data-bank read and write controllers.
- Accepts independent read and write request streams, plus the SRAM-init/software-reset command carried on the write stream.
- Serializes them onto one shared command bus (cmd_addr/cmd_id/cmd_err) with do_rd/do_wr strobes held until completion.
- Enforces bounded fairness between the two streams and drains all outstanding responses before init/reset commands.

---
 rtl/nl2_dbank_cmd_sched.sv | 196 +++++++++++++++++++
 tb/tb_nl2_dbank_cmd_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nl2_dbank_cmd_sched.sv
// Data-bank command scheduler: arbitrates read and write request streams onto
// one held command bus, with bounded fairness and a drain phase before init.
module nl2_dbank_cmd_sched #(
  parameter int unsigned BNK_ADDR_SIZE = 10,
  parameter int unsigned CMD_ID_SIZE   = 1,
  parameter int unsigned MAX_STREAK    = 4
) (
  input  logic                     dbank_ctrl_clk,
  input  logic                     rst_a_n,
  input  logic                     rd_req_valid,
  input  logic [BNK_ADDR_SIZE-1:0] rd_req_addr,
  input  logic [CMD_ID_SIZE-1:0]   rd_req_id,
  input  logic                     rd_req_err,
  output logic                     rd_req_accept,
  input  logic                     wr_req_valid,
  input  logic [BNK_ADDR_SIZE-1:0] wr_req_addr,
  input  logic [CMD_ID_SIZE-1:0]   wr_req_id,
  input  logic                     wr_req_err,
  input  logic                     wr_req_init,
  output logic                     wr_req_accept,
  output logic                     do_rd,
  output logic                     do_wr,
  output logic                     init_cmd,
  output logic [BNK_ADDR_SIZE-1:0] cmd_addr,
  output logic [CMD_ID_SIZE-1:0]   cmd_id,
  output logic                     cmd_err,
  input  logic                     rd_done,
  input  logic                     wr_done,
  input  logic                     init_done,
  input  logic                     rd_idle,
  input  logic                     wr_idle,
  output logic                     sched_idle
);

  // Streak counter holds values up to 15.
  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_DRAIN = 3'd3,
    S_INIT  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [STREAK_W-1:0]      streak_q, streak_d;
  logic                     last_q, last_d;      // 1 = last grant was write
  logic                     do_rd_d, do_wr_d, init_d;
  logic [BNK_ADDR_SIZE-1:0] addr_d;
  logic [CMD_ID_SIZE-1:0]   id_d;
  logic                     err_d;
  logic                     grant_rd, grant_wr, keep_last;
  logic                     other_valid;

  // Arbitration: init wins, single stream wins, otherwise bounded-streak fairness.
  always_comb begin
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    keep_last = 1'b0;
    if (state_q == S_IDLE) begin
      if (wr_req_valid && wr_req_init) begin
        grant_wr = 1'b1;
      end else if (rd_req_valid && wr_req_valid) begin
        // A zero streak means no run in progress, so the opposite stream goes first.
        keep_last = (streak_q != STREAK_W'(0)) && (streak_q < STREAK_MAX);
        if (keep_last) begin
          grant_wr = last_q;
        end else begin
          grant_wr = ~last_q;
        end
        grant_rd = ~grant_wr;
      end else if (rd_req_valid) begin
        grant_rd = 1'b1;
      end else if (wr_req_valid) begin
        grant_wr = 1'b1;
      end
    end
  end

  // Streak bookkeeping for the granted stream.
  always_comb begin
    other_valid = grant_wr ? rd_req_valid : wr_req_valid;
    streak_d    = streak_q;
    last_d      = last_q;
    if (grant_rd || grant_wr) begin
      last_d = grant_wr;
      if (!other_valid) begin
        streak_d = STREAK_W'(0);
      end else if (grant_wr == last_q) begin
        streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + STREAK_W'(1);
      end else begin
        streak_d = STREAK_W'(1);
      end
    end
  end

  // Next-state, command capture and accept strobes.
  always_comb begin
    state_d       = state_q;
    do_rd_d       = do_rd;
    do_wr_d       = do_wr;
    init_d        = init_cmd;
    addr_d        = cmd_addr;
    id_d          = cmd_id;
    err_d         = cmd_err;
    rd_req_accept = 1'b0;
    wr_req_accept = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_rd) begin
          rd_req_accept = 1'b1;
          addr_d        = rd_req_addr;
          id_d          = rd_req_id;
          err_d         = rd_req_err;
          do_rd_d       = 1'b1;
          state_d       = S_RD;
        end else if (grant_wr) begin
          wr_req_accept = 1'b1;
          addr_d        = wr_req_addr;
          id_d          = wr_req_id;
          err_d         = wr_req_err;
          if (wr_req_init) begin
            state_d = S_DRAIN;
          end else begin
            do_wr_d = 1'b1;
            state_d = S_WR;
          end
        end
      end
      S_RD: begin
        if (rd_done) begin
          do_rd_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (wr_done) begin
          do_wr_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (rd_idle && wr_idle) begin
          do_wr_d = 1'b1;
          init_d  = 1'b1;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        // wr_done is deliberately ignored; only init_done closes the command.
        if (init_done) begin
          do_wr_d = 1'b0;
          init_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        do_rd_d = 1'b0;
        do_wr_d = 1'b0;
        init_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Scheduler is idle only with nothing in flight and nothing requested.
  assign sched_idle = (state_q == S_IDLE) && !rd_req_valid && !wr_req_valid;

  // State and registered command outputs.
  always_ff @(posedge dbank_ctrl_clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q  <= S_IDLE;
      streak_q <= STREAK_W'(0);
      last_q   <= 1'b0;
      do_rd    <= 1'b0;
      do_wr    <= 1'b0;
      init_cmd <= 1'b0;
      cmd_addr <= BNK_ADDR_SIZE'(0);
      cmd_id   <= CMD_ID_SIZE'(0);
      cmd_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      last_q   <= last_d;
      do_rd    <= do_rd_d;
      do_wr    <= do_wr_d;
      init_cmd <= init_d;
      cmd_addr <= addr_d;
      cmd_id   <= id_d;
      cmd_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_nl2_dbank_cmd_sched.sv
// Directed bench for nl2_dbank_cmd_sched: cycle table plus hand sequences.
module tb_nl2_dbank_cmd_sched;

  logic       clk;
  logic       rst_n;
  logic       rd_req_valid, rd_req_err, rd_req_accept;
  logic [9:0] rd_req_addr;
  logic [0:0] rd_req_id;
  logic       wr_req_valid, wr_req_err, wr_req_init, wr_req_accept;
  logic [9:0] wr_req_addr;
  logic [0:0] wr_req_id;
  logic       do_rd, do_wr, init_cmd, cmd_err;
  logic [9:0] cmd_addr;
  logic [0:0] cmd_id;
  logic       rd_done, wr_done, init_done, rd_idle, wr_idle, sched_idle;

  int n_cmp = 0;
  int n_err = 0;

  nl2_dbank_cmd_sched #(.BNK_ADDR_SIZE(10), .CMD_ID_SIZE(1), .MAX_STREAK(4)) dut (
    .dbank_ctrl_clk(clk),
    .rst_a_n       (rst_n),
    .rd_req_valid  (rd_req_valid),
    .rd_req_addr   (rd_req_addr),
    .rd_req_id     (rd_req_id),
    .rd_req_err    (rd_req_err),
    .rd_req_accept (rd_req_accept),
    .wr_req_valid  (wr_req_valid),
    .wr_req_addr   (wr_req_addr),
    .wr_req_id     (wr_req_id),
    .wr_req_err    (wr_req_err),
    .wr_req_init   (wr_req_init),
    .wr_req_accept (wr_req_accept),
    .do_rd         (do_rd),
    .do_wr         (do_wr),
    .init_cmd      (init_cmd),
    .cmd_addr      (cmd_addr),
    .cmd_id        (cmd_id),
    .cmd_err       (cmd_err),
    .rd_done       (rd_done),
    .wr_done       (wr_done),
    .init_done     (init_done),
    .rd_idle       (rd_idle),
    .wr_idle       (wr_idle),
    .sched_idle    (sched_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rv, wv;
    logic [9:0] ra, wa;
    logic       rdn, wdn;
    logic       e_racc, e_wacc, e_sidle, e_drd, e_dwr;
    logic [9:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rv, input logic wv, input logic [9:0] ra,
                              input logic [9:0] wa, input logic rdn, input logic wdn,
                              input logic e_racc, input logic e_wacc, input logic e_sidle,
                              input logic e_drd, input logic e_dwr, input logic [9:0] e_addr);
    vec_t v;
    v.rv = rv; v.wv = wv; v.ra = ra; v.wa = wa; v.rdn = rdn; v.wdn = wdn;
    v.e_racc = e_racc; v.e_wacc = e_wacc; v.e_sidle = e_sidle;
    v.e_drd = e_drd; v.e_dwr = e_dwr; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_id = 1'b1; rd_req_err = 1'b0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_id = 1'b0; wr_req_err = 1'b1;
    wr_req_init = 1'b0;
    rd_done = 1'b0; wr_done = 1'b0; init_done = 1'b0;
    rd_idle = 1'b1; wr_idle = 1'b1;
  endtask

  task automatic step_to_post();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] pat;
    logic       g;
    logic [9:0] a;

    // Single read at 0x155: accept, held 5 cycles with a stray wr_done, released.
    vecs.push_back(mk(1, 0, 10'h155, 10'h000, 0, 0, 1, 0, 0, 1, 0, 10'h155));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(0, 0, 10'h000, 10'h000, 0, (i == 2), 0, 0, 0, 1, 0, 10'h155));
    vecs.push_back(mk(0, 0, 10'h000, 10'h000, 1, 0, 0, 0, 0, 0, 0, 10'h155));
    vecs.push_back(mk(0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 1, 0, 0, 10'h155));
    // Both streams valid: W W W W R R R R W (bit i = grant i, 1 = write).
    pat = 9'b1_0000_1111;
    for (int i = 0; i < 9; i++) begin
      g = pat[i];
      a = g ? 10'h0BB : 10'h0AA;
      vecs.push_back(mk(1, 1, 10'h0AA, 10'h0BB, 0, 0, !g, g, 0, !g, g, a));
      vecs.push_back(mk(1, 1, 10'h0AA, 10'h0BB, !g, g, 0, 0, 0, 0, 0, a));
    end
    // Reads only for 20 cycles: every grant is a read.
    for (int i = 0; i < 10; i++) begin
      a = 10'h100 + 10'(i);
      vecs.push_back(mk(1, 0, a, 10'h000, 0, 0, 1, 0, 0, 1, 0, a));
      vecs.push_back(mk(1, 0, a, 10'h000, 1, 0, 0, 0, 0, 0, 0, a));
    end
    // Streak was left at 0, so both-valid switches to write.
    vecs.push_back(mk(1, 1, 10'h111, 10'h222, 0, 0, 0, 1, 0, 0, 1, 10'h222));
    vecs.push_back(mk(0, 0, 10'h000, 10'h000, 0, 1, 0, 0, 0, 0, 0, 10'h222));
    vecs.push_back(mk(0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 1, 0, 0, 10'h222));

    // Reset state.
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_do_rd", 32'(do_rd), 0);
    chk("rst_do_wr", 32'(do_wr), 0);
    chk("rst_init_cmd", 32'(init_cmd), 0);
    chk("rst_cmd_addr", 32'(cmd_addr), 0);
    chk("rst_cmd_id", 32'(cmd_id), 0);
    chk("rst_cmd_err", 32'(cmd_err), 0);
    chk("rst_rd_acc", 32'(rd_req_accept), 0);
    chk("rst_wr_acc", 32'(wr_req_accept), 0);
    chk("rst_sched_idle", 32'(sched_idle), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table phase: drive at negedge, check accepts, then registered outputs.
    foreach (vecs[i]) begin
      @(negedge clk);
      rd_req_valid = vecs[i].rv; rd_req_addr = vecs[i].ra;
      wr_req_valid = vecs[i].wv; wr_req_addr = vecs[i].wa;
      rd_done = vecs[i].rdn; wr_done = vecs[i].wdn;
      #1;
      chk($sformatf("v%0d_rd_acc", i), 32'(rd_req_accept), 32'(vecs[i].e_racc));
      chk($sformatf("v%0d_wr_acc", i), 32'(wr_req_accept), 32'(vecs[i].e_wacc));
      chk($sformatf("v%0d_sched_idle", i), 32'(sched_idle), 32'(vecs[i].e_sidle));
      step_to_post();
      chk($sformatf("v%0d_do_rd", i), 32'(do_rd), 32'(vecs[i].e_drd));
      chk($sformatf("v%0d_do_wr", i), 32'(do_wr), 32'(vecs[i].e_dwr));
      chk($sformatf("v%0d_cmd_addr", i), 32'(cmd_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_drd || vecs[i].e_dwr) begin
        chk($sformatf("v%0d_cmd_id", i), 32'(cmd_id), 32'(vecs[i].e_drd));
        chk($sformatf("v%0d_cmd_err", i), 32'(cmd_err), 32'(vecs[i].e_dwr));
      end
    end

    // Init write with reads still outstanding: drain, then init command.
    @(negedge clk);
    idle_inputs();
    rd_idle = 1'b0;
    wr_req_valid = 1'b1; wr_req_init = 1'b1; wr_req_addr = 10'h3C3;
    rd_req_valid = 1'b1; rd_req_addr = 10'h011;
    #1;
    chk("init_wr_acc", 32'(wr_req_accept), 1);
    chk("init_rd_acc", 32'(rd_req_accept), 0);
    step_to_post();
    chk("init_accept_do_wr", 32'(do_wr), 0);
    chk("init_accept_addr", 32'(cmd_addr), 32'h3C3);
    @(negedge clk);
    wr_req_valid = 1'b0; wr_req_init = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("drain%0d_rd_acc", i), 32'(rd_req_accept), 0);
      step_to_post();
      chk($sformatf("drain%0d_do_wr", i), 32'(do_wr), 0);
      chk($sformatf("drain%0d_init_cmd", i), 32'(init_cmd), 0);
      @(negedge clk);
    end
    rd_idle = 1'b1; rd_req_valid = 1'b0;
    step_to_post();
    chk("init_go_do_wr", 32'(do_wr), 1);
    chk("init_go_init_cmd", 32'(init_cmd), 1);
    @(negedge clk);
    wr_done = 1'b1;
    step_to_post();
    chk("init_stray_done_do_wr", 32'(do_wr), 1);
    chk("init_stray_done_init_cmd", 32'(init_cmd), 1);
    @(negedge clk);
    wr_done = 1'b0; init_done = 1'b1;
    step_to_post();
    chk("init_end_do_wr", 32'(do_wr), 0);
    chk("init_end_init_cmd", 32'(init_cmd), 0);
    @(negedge clk);
    init_done = 1'b0;
    #1;
    chk("init_end_sched_idle", 32'(sched_idle), 1);

    // wr_done with a new write in the same cycle: one-cycle gap in do_wr.
    @(negedge clk);
    wr_req_valid = 1'b1; wr_req_addr = 10'h2D2;
    #1;
    chk("b2b_first_acc", 32'(wr_req_accept), 1);
    step_to_post();
    chk("b2b_first_do_wr", 32'(do_wr), 1);
    chk("b2b_first_addr", 32'(cmd_addr), 32'h2D2);
    @(negedge clk);
    wr_req_addr = 10'h1E1; wr_done = 1'b1;
    #1;
    chk("b2b_done_cycle_acc", 32'(wr_req_accept), 0);
    step_to_post();
    chk("b2b_gap_do_wr", 32'(do_wr), 0);
    @(negedge clk);
    wr_done = 1'b0;
    #1;
    chk("b2b_second_acc", 32'(wr_req_accept), 1);
    step_to_post();
    chk("b2b_second_do_wr", 32'(do_wr), 1);
    chk("b2b_second_addr", 32'(cmd_addr), 32'h1E1);

    // Asynchronous reset in the middle of a write command.
    @(negedge clk);
    wr_req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_do_wr", 32'(do_wr), 0);
    chk("mid_rst_addr", 32'(cmd_addr), 0);
    chk("mid_rst_err", 32'(cmd_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_sched_idle", 32'(sched_idle), 1);
    chk("post_rst_wr_acc", 32'(wr_req_accept), 0);
    step_to_post();
    chk("post_rst_do_wr", 32'(do_wr), 0);
    chk("post_rst_do_rd", 32'(do_rd), 0);
    @(negedge clk);
    rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    rd_req_addr = 10'h077; wr_req_addr = 10'h088;
    #1;
    chk("post_rst_first_wr_acc", 32'(wr_req_accept), 1);
    chk("post_rst_first_rd_acc", 32'(rd_req_accept), 0);
    step_to_post();
    chk("post_rst_first_do_wr", 32'(do_wr), 1);
    chk("post_rst_first_addr", 32'(cmd_addr), 32'h088);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
